// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_decoder
// Description : Receiver for a ticked Morse light stream. Mark lengths are
//               classified as dot or dash, a long space ends the letter,
//               and the element sequence is decoded to the 3-bit code A-H.
// Ports       : Clock        - system clock
//               Reset        - synchronous, active-high reset
//               tick         - one-cycle sample enable per half-second period
//               mc_in        - Morse light, 1 = mark, 0 = space
//               letter       - decoded letter code (0=A .. 7=H)
//               letter_valid - one-cycle pulse, letter/err valid in that cycle
//               err          - last letter malformed or not in the table
//               busy         - a letter is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module morse_decoder #(
  parameter int GAP_TICKS  = 3,  // consecutive low samples ending a letter (2..7)
  parameter int DASH_TICKS = 3   // longest legal mark length in ticks
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       mc_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // The space counter starts at 1 on the first low sample, so the letter
  // ends when the counter already holds GAP_TICKS-1 and another low arrives.
  localparam logic [2:0] GAP_LAST = 3'(GAP_TICKS - 1);
  localparam logic [2:0] DASH_MAX = 3'(DASH_TICKS);

  state_t     state;
  logic [2:0] cnt;      // saturating run length of the current mark/space
  logic [2:0] n;        // number of elements captured so far
  logic [3:0] pattern;  // bit i = element i, 1 = dash
  logic       bad;      // sticky malformed-letter flag

  logic       match;
  logic [2:0] code;

  // Unwritten pattern bits stay 0, so the full 4-bit pattern is compared.
  always_comb begin
    match = 1'b1;
    code  = 3'd0;
    case ({n, pattern})
      {3'd2, 4'b0010}: code = 3'd0;  // A .-
      {3'd4, 4'b0001}: code = 3'd1;  // B -...
      {3'd4, 4'b0101}: code = 3'd2;  // C -.-.
      {3'd3, 4'b0001}: code = 3'd3;  // D -..
      {3'd1, 4'b0000}: code = 3'd4;  // E .
      {3'd4, 4'b0100}: code = 3'd5;  // F ..-.
      {3'd3, 4'b0011}: code = 3'd6;  // G --.
      {3'd4, 4'b0000}: code = 3'd7;  // H ....
      default:         match = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      n            <= 3'd0;
      pattern      <= 4'd0;
      bad          <= 1'b0;
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (mc_in) begin
              cnt     <= 3'd1;
              n       <= 3'd0;
              pattern <= 4'd0;
              bad     <= 1'b0;
              state   <= MARK;
            end
          end

          MARK: begin
            if (mc_in) begin
              if (cnt != 3'd7) cnt <= cnt + 3'd1;
            end else begin
              // A saturated mark is always longer than DASH_MAX, so it
              // can never wrap back into a dot.
              if (cnt > DASH_MAX || n == 3'd4) bad <= 1'b1;
              if (n != 3'd4) begin
                pattern[n[1:0]] <= (cnt != 3'd1);
                n               <= n + 3'd1;
              end
              cnt   <= 3'd1;
              state <= SPACE;
            end
          end

          SPACE: begin
            if (mc_in) begin
              cnt   <= 3'd1;
              state <= MARK;
            end else if (cnt == GAP_LAST) begin
              letter_valid <= 1'b1;
              if (match && !bad) begin
                letter <= code;
                err    <= 1'b0;
              end else begin
                letter <= 3'd0;
                err    <= 1'b1;
              end
              cnt   <= 3'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_decoder
// Description : Self-checking bench for morse_decoder. Expected letters are
//               queued as each letter is driven and compared whenever the
//               decoder pulses letter_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       mc_in = 1'b0;
  logic [2:0] letter;
  logic       letter_valid;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];  // {letter, err}

  morse_decoder #(.GAP_TICKS(3), .DASH_TICKS(3)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .tick        (tick),
    .mc_in       (mc_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every letter_valid must match the oldest queued letter.
  always @(negedge clk) begin
    if (letter_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed letter %0d err %0b expected no pulse", letter, err);
      end
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({letter, err} === e) else begin
          errors++;
          $error("FAIL letter_out: observed letter %0d err %0b expected letter %0d err %0b",
                 letter, err, e[3:1], e[0]);
        end
      end
    end
  end

  // One sample period: tick for one cycle, then one idle cycle.
  task automatic do_tick(input logic m, output logic lv_after, output logic lv_idle);
    @(posedge clk); #1;
    tick  = 1'b1;
    mc_in = m;
    @(posedge clk); #1;
    tick     = 1'b0;
    lv_after = letter_valid;
    @(posedge clk); #1;
    lv_idle  = letter_valid;
  endtask

  task automatic send_str(input string tag, input string s, input logic [2:0] el,
                          input logic ee, input bit ends);
    logic lv, lvi;
    if (ends) exp_q.push_back({el, ee});
    for (int i = 0; i < s.len(); i++) begin
      do_tick(s[i] == 8'h31, lv, lvi);
      if (i == 0) chk({tag, "_busy_start"}, busy, 1);
      if (i == s.len() - 1) begin
        chk({tag, "_valid_latency"}, lv, ends);
        chk({tag, "_valid_clears"}, lvi, 0);
      end
    end
    if (ends) chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    string morse[8];
    string s, m;
    morse = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    // Reset held with tick active: reset must win.
    tick  = 1'b1;
    mc_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b0;
    chk("reset_letter", letter, 0);
    chk("reset_valid", letter_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    send_str("A", "10111000", 3'd0, 1'b0, 1'b1);
    chk("A_hold_letter", letter, 0);
    send_str("H", "1010101000", 3'd7, 1'b0, 1'b1);
    send_str("E", "1000", 3'd4, 1'b0, 1'b1);
    chk("E_hold_letter", letter, 4);
    send_str("long_mark", "111111111000", 3'd0, 1'b1, 1'b1);
    chk("long_mark_hold_err", err, 1);
    send_str("overflow", "101010101000", 3'd0, 1'b1, 1'b1);
    send_str("unknown", "11101110111000", 3'd0, 1'b1, 1'b1);
    send_str("D", "1110101000", 3'd3, 1'b0, 1'b1);

    // Reset mid-letter, asserted together with a tick.
    send_str("partial", "101", 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; tick = 1'b1; mc_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; tick = 1'b0;
    chk("midreset_busy", busy, 0);
    send_str("C", "11101011101000", 3'd2, 1'b0, 1'b1);

    // Toggling mc_in without ticks must not disturb the idle decoder.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      mc_in = ~mc_in;
    end
    chk("gate_idle_busy", busy, 0);

    // Same mid-letter: the half-received A must resume intact.
    send_str("gateA1", "1", 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      mc_in = ~mc_in;
    end
    chk("gate_mid_busy", busy, 1);
    send_str("gateA2", "0111000", 3'd0, 1'b0, 1'b1);

    // Loopback with standard transmitter timing for every code.
    for (int k = 0; k < 8; k++) begin
      m = morse[k];
      s = "";
      for (int j = 0; j < m.len(); j++) begin
        if (j > 0) s = {s, "0"};
        s = {s, (m[j] == 8'h2D) ? "111" : "1"};
      end
      s = {s, "000"};
      send_str($sformatf("loop%0d", k), s, 3'(k), 1'b0, 1'b1);
      chk($sformatf("loop%0d_letter", k), letter, k);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
